// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates icache/dcache miss traffic onto the single memory port
// Optional ARB_ROUND_ROBIN_EN: simultaneous requests go to whichever side was not last_owner.
module mem_arbiter #(
  parameter int BURST_MAX = 8,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_rw_flag,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic [3:0]  i_write_mask,
  output logic [31:0] i_read_data,
  output logic        i_busy,
  output logic        i_done,
  input  logic [1:0]  d_rw_flag,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_write_data,
  input  logic [3:0]  d_write_mask,
  output logic [31:0] d_read_data,
  output logic        d_busy,
  output logic        d_done,
  output logic [1:0]  mem_rw_flag,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy,
  input  logic        mem_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             owner_d, win_d, issue, prev_resp;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic             i_req, d_req, own_req, oth_req, chain, pick_d;
  logic             in_flight;
`ifdef ARB_ROUND_ROBIN_EN
  logic             last_owner_d;
`endif

  assign i_req     = |i_rw_flag;
  assign d_req     = |d_rw_flag;
  assign own_req   = owner_d ? d_req : i_req;
  assign oth_req   = owner_d ? i_req : d_req;
  // Chaining is only offered in the cycle straight after the owner's done.
  assign chain     = prev_resp && own_req;
  assign in_flight = (state == ISSUE) || (state == WAIT);

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_d = d_req && !(i_req && last_owner_d);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    win_d     = owner_d;
    cnt_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        if ((i_req || d_req) && !mem_busy) begin
          state_nxt = ISSUE;
          issue     = 1'b1;
          if (chain && (burst_cnt < CNT_W'(BURST_MAX - 1))) begin
            win_d   = owner_d;
            cnt_nxt = burst_cnt + CNT_W'(1);
          end else if (chain && oth_req) begin
            // Saturated burst: hand the port to the waiting side.
            win_d   = !owner_d;
            cnt_nxt = '0;
          end else begin
            win_d   = pick_d;
            cnt_nxt = '0;
          end
        end
      end
      ISSUE, WAIT: begin
        if (mem_done)            state_nxt = RESP;
        else if (state == ISSUE) state_nxt = WAIT;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_d        <= 1'b1;
      burst_cnt      <= '0;
      prev_resp      <= 1'b0;
      mem_rw_flag    <= 2'b00;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_write_mask <= '0;
      i_read_data    <= '0;
      d_read_data    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_d   <= 1'b1;
`endif
    end else begin
      prev_resp <= (state == RESP);
      if (issue) begin
        owner_d        <= win_d;
        burst_cnt      <= cnt_nxt;
        mem_rw_flag    <= (win_d ? d_rw_flag[1] : i_rw_flag[1]) ? 2'b10 : 2'b01;
        mem_addr       <= win_d ? d_addr : i_addr;
        mem_write_data <= win_d ? d_write_data : i_write_data;
        mem_write_mask <= win_d ? d_write_mask : i_write_mask;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d   <= win_d;
`endif
      end else if (state == ISSUE) begin
        mem_rw_flag <= 2'b00;
      end
      if (in_flight && mem_done) begin
        if (owner_d) d_read_data <= mem_read_data;
        else         i_read_data <= mem_read_data;
      end
    end
  end

  assign i_done = (state == RESP) && !owner_d;
  assign d_done = (state == RESP) && owner_d;
  // Owner stays busy even if it drops its flag mid-transaction.
  assign i_busy = rst && !i_done && (i_req || (in_flight && !owner_d));
  assign d_busy = rst && !d_done && (d_req || (in_flight && owner_d));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with cache and memory models
module tb_mem_arbiter;

  typedef struct {
    logic [1:0]  flag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  typedef struct {
    bit          is_d;
    logic [1:0]  mflag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    int          lat;
    int          issue_cyc;
  } exp_t;

  typedef struct {
    req_t ir;
    req_t dr;
    int   lat;
    bit   d_first;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_rw_flag, d_rw_flag, mem_rw_flag;
  logic [31:0] i_addr, i_write_data, i_read_data;
  logic [31:0] d_addr, d_write_data, d_read_data;
  logic [3:0]  i_write_mask, d_write_mask, mem_write_mask;
  logic        i_busy, i_done, d_busy, d_done;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_busy, mem_done;

  req_t i_q[$];
  req_t d_q[$];
  exp_t exp_q[$];
  exp_t done_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mem_lat = 2;
  bit   prev_flag = 1'b0;

  mem_arbiter #(.BURST_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_rw_flag(i_rw_flag), .i_addr(i_addr), .i_write_data(i_write_data),
    .i_write_mask(i_write_mask), .i_read_data(i_read_data), .i_busy(i_busy), .i_done(i_done),
    .d_rw_flag(d_rw_flag), .d_addr(d_addr), .d_write_data(d_write_data),
    .d_write_mask(d_write_mask), .d_read_data(d_read_data), .d_busy(d_busy), .d_done(d_done),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_read_data(mem_read_data),
    .mem_busy(mem_busy), .mem_done(mem_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic req_t rq(input logic [1:0] f, input logic [31:0] a,
                              input logic [31:0] w, input logic [3:0] m);
    req_t r;
    r.flag = f; r.addr = a; r.wdata = w; r.mask = m;
    return r;
  endfunction

  function automatic exp_t mk(input bit is_d, input req_t r, input int lat);
    exp_t e;
    e.is_d = is_d; e.mflag = r.flag[1] ? 2'b10 : 2'b01; e.addr = r.addr;
    e.wdata = r.wdata; e.mask = r.mask; e.rdata = mem_val(r.addr);
    e.lat = lat; e.issue_cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_i(input req_t r, input int lat);
    i_q.push_back(r);
    exp_q.push_back(mk(1'b0, r, lat));
  endtask

  task automatic push_d(input req_t r, input int lat);
    d_q.push_back(r);
    exp_q.push_back(mk(1'b1, r, lat));
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (i_q.size() == 0 && d_q.size() == 0 && exp_q.size() == 0 && done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", {63'b0, ok}, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  // icache model: holds each request until its done, then presents the next one
  initial begin
    i_rw_flag = 2'b00; i_addr = '0; i_write_data = '0; i_write_mask = '0;
    forever begin
      @(negedge clk);
      if (i_done && i_q.size() > 0) i_q.delete(0);
      if (i_q.size() > 0) begin
        i_rw_flag = i_q[0].flag; i_addr = i_q[0].addr;
        i_write_data = i_q[0].wdata; i_write_mask = i_q[0].mask;
      end else i_rw_flag = 2'b00;
    end
  end

  initial begin
    d_rw_flag = 2'b00; d_addr = '0; d_write_data = '0; d_write_mask = '0;
    forever begin
      @(negedge clk);
      if (d_done && d_q.size() > 0) d_q.delete(0);
      if (d_q.size() > 0) begin
        d_rw_flag = d_q[0].flag; d_addr = d_q[0].addr;
        d_write_data = d_q[0].wdata; d_write_mask = d_q[0].mask;
      end else d_rw_flag = 2'b00;
    end
  end

  // memory model: done mem_lat cycles after the issue cycle, garbage data otherwise
  initial begin
    bit          pend = 1'b0;
    int          cd = 0;
    logic [31:0] ma = '0;
    mem_done = 1'b0; mem_read_data = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      mem_read_data = $urandom;
      if (!rst) pend = 1'b0;
      else begin
        if (mem_rw_flag != 2'b00) begin pend = 1'b1; cd = mem_lat; ma = mem_addr; end
        if (pend) begin
          if (cd == 0) begin mem_done = 1'b1; mem_read_data = mem_val(ma); pend = 1'b0; end
          else cd--;
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        done_q.delete();
        prev_flag = 1'b0;
      end else begin
        if (mem_rw_flag != 2'b00) begin
          chk("flag_one_cycle", {63'b0, prev_flag}, 64'd0);
          if (exp_q.size() == 0) chk("unexpected_issue", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("mem_rw_flag", 64'(mem_rw_flag), 64'(e.mflag));
            chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            chk("mem_write_data", 64'(mem_write_data), 64'(e.wdata));
            chk("mem_write_mask", 64'(mem_write_mask), 64'(e.mask));
            e.issue_cyc = cyc;
            done_q.push_back(e);
          end
        end
        prev_flag = (mem_rw_flag != 2'b00);
        if (i_done || d_done) begin
          chk("single_done", {63'b0, i_done & d_done}, 64'd0);
          if (done_q.size() == 0) chk("unexpected_done", {62'b0, d_done, i_done}, 64'd0);
          else begin
            e = done_q.pop_front();
            chk("done_side", {63'b0, d_done}, {63'b0, e.is_d});
            chk("read_data", 64'(d_done ? d_read_data : i_read_data), 64'(e.rdata));
            chk("done_latency", 64'(cyc - e.issue_cyc), 64'(e.lat + 1));
          end
        end
        if (i_done) chk("i_busy_at_done", {63'b0, i_busy}, 64'd0);
        else if (i_rw_flag != 2'b00) chk("i_busy_pending", {63'b0, i_busy}, 64'd1);
        if (d_done) chk("d_busy_at_done", {63'b0, d_busy}, 64'd0);
        else if (d_rw_flag != 2'b00) chk("d_busy_pending", {63'b0, d_busy}, 64'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (errors so far %0d)", n_fail);
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    bit   seen;
    req_t nul;
    nul = rq(2'b00, 32'h0, 32'h0, 4'h0);
    vecs[0] = '{rq(2'b01, 32'h100, 32'h0, 4'h0), nul, 3, 1'b0};
    vecs[1] = '{rq(2'b01, 32'h200, 32'h0, 4'h0), rq(2'b10, 32'h300, 32'h12345678, 4'hF), 2, 1'b1};
    vecs[2] = '{nul, rq(2'b01, 32'h400, 32'h0, 4'h0), 0, 1'b1};
    vecs[3] = '{rq(2'b11, 32'h500, 32'hAABBCCDD, 4'h5), nul, 1, 1'b0};
    vecs[4] = '{rq(2'b01, 32'h600, 32'h0, 4'h0), rq(2'b11, 32'h700, 32'hCAFEF00D, 4'h3), 0, 1'b1};
    vecs[5] = '{nul, rq(2'b01, 32'h800, 32'h0, 4'h0), 5, 1'b1};

    rst = 1'b0;
    mem_busy = 1'b0;
    mem_lat = 2;
    push_d(rq(2'b01, 32'h40, 32'h0, 4'h0), 2);
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("rst_mem_rw_flag", 64'(mem_rw_flag), 64'd0);
      chk("rst_mem_addr_data", {mem_addr, mem_write_data}, 64'd0);
      chk("rst_read_data", {i_read_data, d_read_data}, 64'd0);
      chk("rst_ctrl", {56'b0, mem_write_mask, i_busy, i_done, d_busy, d_done}, 64'd0);
    end
    rst = 1'b1;
    wait_drain();

    for (int v = 0; v < 6; v++) begin
      @(posedge clk);
      #1;
      mem_lat = vecs[v].lat;
      if (vecs[v].d_first) begin
        if (vecs[v].dr.flag != 2'b00) push_d(vecs[v].dr, vecs[v].lat);
        if (vecs[v].ir.flag != 2'b00) push_i(vecs[v].ir, vecs[v].lat);
      end else begin
        if (vecs[v].ir.flag != 2'b00) push_i(vecs[v].ir, vecs[v].lat);
        if (vecs[v].dr.flag != 2'b00) push_d(vecs[v].dr, vecs[v].lat);
      end
      wait_drain();
    end

    // burst: 8 chained dcache reads, forced handoff to icache, then the rest
    @(posedge clk);
    #1;
    mem_lat = 1;
    for (int k = 0; k < 10; k++) d_q.push_back(rq(2'b01, 32'h1000 + 32'(k * 4), 32'h0, 4'h0));
    i_q.push_back(rq(2'b01, 32'h2000, 32'h0, 4'h0));
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(1'b1, d_q[k], 1));
    exp_q.push_back(mk(1'b0, i_q[0], 1));
    for (int k = 8; k < 10; k++) exp_q.push_back(mk(1'b1, d_q[k], 1));
    wait_drain();

    // memory busy stalls the issue
    mem_busy = 1'b1;
    push_i(rq(2'b01, 32'h900, 32'h0, 4'h0), 1);
    repeat (5) begin
      @(negedge clk);
      #2;
      chk("stall_no_issue", 64'(mem_rw_flag), 64'd0);
      chk("stall_i_busy", {63'b0, i_busy}, 64'd1);
    end
    mem_busy = 1'b0;
    @(negedge clk);
    #2;
    chk("stall_release_issue", 64'(mem_rw_flag), 64'd1);
    wait_drain();

    // reset while waiting on memory: abandoned, then reissued and completed
    mem_lat = 6;
    push_d(rq(2'b01, 32'hA00, 32'h0, 4'h0), 6);
    exp_q.push_back(mk(1'b1, rq(2'b01, 32'hA00, 32'h0, 4'h0), 6));
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #2;
      if (mem_rw_flag != 2'b00) begin seen = 1'b1; break; end
    end
    chk("wait_issue_before_rst", {63'b0, seen}, 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("rst_mid_no_done", {62'b0, i_done, d_done}, 64'd0);
      chk("rst_mid_flag", 64'(mem_rw_flag), 64'd0);
    end
    rst = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
